similarity_search_ctrl: RTL

Sequencer that runs a nearest-class search on the shared floating-point cosine similarity engine. It streams a query hypervector and each of NUM_CLASSES class hypervectors from a single-port hypervector memory into the engine, one element pair at a time. It collects one FP32 score per class and reports the index and score of the best match. It sits between the hypervector memory and the cosine similarity engine, and is started by the top-level HDC inference controller.

---
 rtl/similarity_search_ctrl_if.sv | 39 +++
 rtl/similarity_search_ctrl.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/similarity_search_ctrl_if.sv
// Memory, engine and host-control signals of the similarity search sequencer.
interface similarity_search_ctrl_if #(
  parameter int unsigned HV_DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH    = 16,
  parameter int unsigned NUM_CLASSES   = 16
);
  localparam int unsigned CLS_W = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;

  logic                     start;
  logic [ADDR_WIDTH-1:0]    q_base;
  logic [ADDR_WIDTH-1:0]    c_base;
  logic                     mem_rd_en;
  logic [ADDR_WIDTH-1:0]    mem_addr;
  logic [HV_DATA_WIDTH-1:0] mem_rd_data;
  logic                     eng_valid;
  logic                     eng_first;
  logic                     eng_last;
  logic                     eng_end;
  logic [HV_DATA_WIDTH-1:0] eng_data;
  logic                     eng_ready;
  logic                     eng_done;
  logic [HV_DATA_WIDTH-1:0] eng_result;
  logic                     busy;
  logic                     done;
  logic [CLS_W-1:0]         best_class;
  logic [HV_DATA_WIDTH-1:0] best_score;

  modport master (
    input  start, q_base, c_base, mem_rd_data, eng_ready, eng_done, eng_result,
    output mem_rd_en, mem_addr, eng_valid, eng_first, eng_last, eng_end, eng_data,
           busy, done, best_class, best_score
  );

  modport slave (
    output start, q_base, c_base, mem_rd_data, eng_ready, eng_done, eng_result,
    input  mem_rd_en, mem_addr, eng_valid, eng_first, eng_last, eng_end, eng_data,
           busy, done, best_class, best_score
  );
endinterface

// File: rtl/similarity_search_ctrl.sv
// Streams query/class hypervector pairs into the cosine engine and keeps the best-scoring class.
module similarity_search_ctrl #(
  parameter int unsigned HV_DATA_WIDTH = 32,
  parameter int unsigned HV_DIM        = 1024,
  parameter int unsigned NUM_CLASSES   = 16,
  parameter int unsigned ADDR_WIDTH    = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  similarity_search_ctrl_if.master bus
);
  localparam int unsigned ELEM_W = (HV_DIM > 1) ? $clog2(HV_DIM) : 1;
  localparam int unsigned CLS_W  = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;
  localparam int unsigned MSB    = HV_DATA_WIDTH - 1;
  localparam logic [ELEM_W-1:0]     ELEM_LAST  = ELEM_W'(HV_DIM - 1);
  localparam logic [CLS_W-1:0]      CLS_LAST   = CLS_W'(NUM_CLASSES - 1);
  localparam logic [ADDR_WIDTH-1:0] CLS_STRIDE = ADDR_WIDTH'(HV_DIM);

  typedef enum logic [3:0] {
    IDLE, RD_A, RD_B, LAT_B, SEND_A, SEND_B, WAIT_DONE, COMPARE, FINISH
  } state_t;

  state_t                   state;
  logic [ADDR_WIDTH-1:0]    q_base_r;
  logic [ADDR_WIDTH-1:0]    c_base_r;
  logic [ADDR_WIDTH-1:0]    cls_off;
  logic [ELEM_W-1:0]        elem_idx;
  logic [CLS_W-1:0]         class_idx;
  logic                     best_valid;
  logic [HV_DATA_WIDTH-1:0] a_reg;
  logic [HV_DATA_WIDTH-1:0] b_reg;
  logic [HV_DATA_WIDTH-1:0] score_reg;
  logic [ELEM_W-1:0]        elem_nxt;

  assign elem_nxt = elem_idx + ELEM_W'(1);

  // Signed FP ordering on raw bit patterns; +0 and -0 compare equal.
  function automatic logic fp_gt(input logic [HV_DATA_WIDTH-1:0] a,
                                 input logic [HV_DATA_WIDTH-1:0] b);
    logic [HV_DATA_WIDTH-2:0] ma;
    logic [HV_DATA_WIDTH-2:0] mb;
    ma = a[MSB-1:0];
    mb = b[MSB-1:0];
    if (ma == '0 && mb == '0) return 1'b0;
    if (a[MSB] != b[MSB])     return b[MSB];
    if (!a[MSB])              return ma > mb;
    return ma < mb;
  endfunction

  // Outputs are registered and loaded for the state being entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      q_base_r       <= '0;
      c_base_r       <= '0;
      cls_off        <= '0;
      elem_idx       <= '0;
      class_idx      <= '0;
      best_valid     <= 1'b0;
      a_reg          <= '0;
      b_reg          <= '0;
      score_reg      <= '0;
      bus.mem_rd_en  <= 1'b0;
      bus.mem_addr   <= '0;
      bus.eng_valid  <= 1'b0;
      bus.eng_first  <= 1'b0;
      bus.eng_last   <= 1'b0;
      bus.eng_end    <= 1'b0;
      bus.eng_data   <= '0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.best_class <= '0;
      bus.best_score <= '0;
    end else begin
      bus.mem_rd_en <= 1'b0;
      bus.done      <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            q_base_r      <= bus.q_base;
            c_base_r      <= bus.c_base;
            cls_off       <= '0;
            elem_idx      <= '0;
            class_idx     <= '0;
            best_valid    <= 1'b0;
            bus.busy      <= 1'b1;
            bus.mem_rd_en <= 1'b1;
            bus.mem_addr  <= bus.q_base;
            state         <= RD_A;
          end
        end
        RD_A: begin
          bus.mem_rd_en <= 1'b1;
          bus.mem_addr  <= c_base_r + cls_off + ADDR_WIDTH'(elem_idx);
          state         <= RD_B;
        end
        RD_B: begin
          a_reg <= bus.mem_rd_data;
          state <= LAT_B;
        end
        LAT_B: begin
          b_reg         <= bus.mem_rd_data;
          bus.eng_valid <= 1'b1;
          bus.eng_first <= 1'b1;
          bus.eng_data  <= a_reg;
          state         <= SEND_A;
        end
        SEND_A: begin
          if (bus.eng_ready) begin
            bus.eng_first <= 1'b0;
            bus.eng_last  <= 1'b1;
            bus.eng_end   <= (elem_idx == ELEM_LAST);
            bus.eng_data  <= b_reg;
            state         <= SEND_B;
          end
        end
        SEND_B: begin
          if (bus.eng_ready) begin
            bus.eng_valid <= 1'b0;
            bus.eng_last  <= 1'b0;
            bus.eng_end   <= 1'b0;
            if (elem_idx == ELEM_LAST) begin
              state <= WAIT_DONE;
            end else begin
              elem_idx      <= elem_nxt;
              bus.mem_rd_en <= 1'b1;
              bus.mem_addr  <= q_base_r + ADDR_WIDTH'(elem_nxt);
              state         <= RD_A;
            end
          end
        end
        WAIT_DONE: begin
          if (bus.eng_done) begin
            score_reg <= bus.eng_result;
            state     <= COMPARE;
          end
        end
        COMPARE: begin
          // Strict greater-than keeps the lower class index on ties.
          if (!best_valid || fp_gt(score_reg, bus.best_score)) begin
            best_valid     <= 1'b1;
            bus.best_class <= class_idx;
            bus.best_score <= score_reg;
          end
          if (class_idx == CLS_LAST) begin
            bus.done <= 1'b1;
            state    <= FINISH;
          end else begin
            class_idx     <= class_idx + CLS_W'(1);
            cls_off       <= cls_off + CLS_STRIDE;
            elem_idx      <= '0;
            bus.mem_rd_en <= 1'b1;
            bus.mem_addr  <= q_base_r;
            state         <= RD_A;
          end
        end
        FINISH: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
